mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
- MEM-stage load/store unit of the 5-stage RV32I pipeline; sits between the EX/MEM and MEM/WB pipeline registers.
- Consumes the `forward_mem` select from the store-data forwarding unit. When `forward_mem` is high, a store takes its data from the MEM/WB result instead of `rs2_data_EXMEM`.
- Drives a single-outstanding data-memory request/ready handshake, formats load data, stalls the front of the pipeline while memory is busy, and owns the MEM/WB register.

Parameters:
- XLEN, 32, datapath width.
- ADDR_W, 32, data-memory address width.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- valid_EXMEM  in  1  EX/MEM holds a real instruction
- alu_result_EXMEM  in  XLEN  effective address, or ALU result for non-memory ops
- rs2_data_EXMEM  in  XLEN  store data from the register file
- rd_EXMEM  in  5  destination register
- funct3_EXMEM  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- store_flag_EXMEM  in  1  instruction is a store
- load_flag_EXMEM  in  1  instruction is a load
- reg_write_EXMEM  in  1  instruction writes rd
- forward_mem  in  1  select `result_MEMWB` as store data
- dmem_req  out  1  request valid
- dmem_we  out  1  write request
- dmem_addr  out  ADDR_W  word-aligned address (low 2 bits forced to 0)
- dmem_be  out  4  byte enables
- dmem_wdata  out  XLEN  lane-aligned store data
- dmem_ready  in  1  request complete; `dmem_rdata` is valid in the same cycle
- dmem_rdata  in  XLEN  read word
- stall_mem  out  1  hold IF..EX/MEM this cycle
- misaligned_exc  out  1  one-cycle pulse on a misaligned access
- valid_MEMWB, reg_write_MEMWB, load_flag_MEMWB  out  1 each  MEM/WB control
- rd_MEMWB  out  5  MEM/WB destination
- result_MEMWB  out  XLEN  writeback value (ALU result or formatted load)

Behaviour:
- Reset (async, `rst_n` = 0):
  - FSM goes to IDLE.
  - All outputs are 0, including `dmem_req`, `stall_mem`, `misaligned_exc` and all MEM/WB fields.
  - Any in-flight request is abandoned; `dmem_ready` is ignored until the FSM leaves reset.
- FSM states: IDLE, REQ.
- Memory op present = `valid_EXMEM` & (`store_flag_EXMEM` | `load_flag_EXMEM`).
- Misalignment rule: H/HU with `addr[0]` = 1, or W with `addr[1:0]` != 0.
- IDLE, no memory op:
  - MEM/WB <= EX/MEM fields, with `result_MEMWB` = `alu_result_EXMEM`.
  - `stall_mem` = 0; latency is 1 cycle.
- IDLE, misaligned memory op:
  - `misaligned_exc` = 1 for exactly that cycle.
  - No request is issued and `stall_mem` = 0.
  - MEM/WB <= bubble (`valid`, `reg_write`, `load_flag` all 0).
- IDLE, aligned memory op:
  - `stall_mem` = 1.
  - Latch address, `funct3`, `rd`, flags, byte enables and store data into request registers.
  - MEM/WB <= bubble.
  - Next state REQ.
- Store data is captured only in the IDLE accept cycle:
  - Source is `result_MEMWB` when `forward_mem` = 1, otherwise `rs2_data_EXMEM`.
  - MEM/WB is still the older instruction in that cycle, so forwarding is valid.
- Store lane alignment:
  - SB: data replicated into all 4 bytes; `be` = 0001 shifted left by `addr[1:0]`.
  - SH: data replicated into both halves; `be` = 0011 or 1100, chosen by `addr[1]`.
  - SW: `be` = 1111.
- Loads drive `dmem_we` = 0 and `be` = 1111.
- REQ:
  - `dmem_req` = 1, `dmem_we`/`addr`/`be`/`wdata` held stable until `dmem_ready`.
  - `stall_mem` = 1 while `dmem_ready` = 0. `stall_mem` = !`dmem_ready` combinationally, so EX/MEM advances in the completion cycle.
  - MEM/WB holds bubble while waiting.
- REQ completion (`dmem_ready` = 1):
  - Load: MEM/WB <= {valid 1, `reg_write` 1, `load_flag` 1, `rd`, formatted data}.
  - Store: MEM/WB <= {valid 1, `reg_write` 0, `load_flag` 0}.
  - Next state IDLE.
- Load formatting: select byte/half by `addr[1:0]`; B/H sign-extend, BU/HU zero-extend, W passes through.
- Minimum memory-op latency is 2 cycles: accept cycle plus completion cycle with `dmem_ready` already high.
- No new request is accepted while in REQ. The instruction behind the memory op is held by `stall_mem`.
- `dmem_ready` in IDLE is ignored.
- `rd` = x0 loads still complete, with `reg_write` forced to 0.

Test Plan:
- LW `addr` 0x100, `dmem_rdata` 0xDEADBEEF, ready one cycle after `dmem_req` -> `stall_mem` high for 2 cycles; then MEM/WB result 0xDEADBEEF, `load_flag` 1, `reg_write` 1.
- LB `addr` 0x103, `dmem_rdata` 0x80112233, ready immediately -> `result_MEMWB` 0xFFFFFF80. The same case as LBU -> 0x00000080.
- LW x5 followed by SB x5 to 0x202 with `forward_mem` = 1, load result 0x000000AB -> `dmem_be` 0100, `dmem_wdata` 0xABABABAB, `dmem_we` 1; `rs2_data` ignored.
- SH to 0x301 -> `misaligned_exc` pulses 1 cycle, `dmem_req` never asserts, MEM/WB bubble, `stall_mem` 0.
- `rst_n` driven low during REQ with `dmem_ready` = 0 -> `dmem_req`, `stall_mem` and all MEM/WB outputs go to 0 immediately; after release the next ADD passes through in 1 cycle.
- Back-to-back ADD, SW, ADD with `dmem_ready` delayed 3 cycles -> second ADD appears in MEM/WB exactly one cycle after the SW completion; no duplicate or lost instruction.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: single-outstanding data-memory handshake,
// store lane alignment, load formatting and the MEM/WB pipeline register.
module mem_stage_lsu #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_EXMEM,
    input  logic [XLEN-1:0]   alu_result_EXMEM,
    input  logic [XLEN-1:0]   rs2_data_EXMEM,
    input  logic [4:0]        rd_EXMEM,
    input  logic [2:0]        funct3_EXMEM,
    input  logic              store_flag_EXMEM,
    input  logic              load_flag_EXMEM,
    input  logic              reg_write_EXMEM,
    input  logic              forward_mem,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_ready,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              stall_mem,
    output logic              misaligned_exc,
    output logic              valid_MEMWB,
    output logic              reg_write_MEMWB,
    output logic              load_flag_MEMWB,
    output logic [4:0]        rd_MEMWB,
    output logic [XLEN-1:0]   result_MEMWB
);

    typedef enum logic {IDLE, REQ} state_t;

    state_t state_q, state_d;

    // Request registers, stable for the whole REQ phase
    logic [ADDR_W-1:0] req_addr_q,  req_addr_d;
    logic [1:0]        req_off_q,   req_off_d;
    logic [2:0]        req_f3_q,    req_f3_d;
    logic [4:0]        req_rd_q,    req_rd_d;
    logic              req_store_q, req_store_d;
    logic [3:0]        req_be_q,    req_be_d;
    logic [XLEN-1:0]   req_wdata_q, req_wdata_d;

    // MEM/WB register
    logic              wb_valid_q, wb_valid_d;
    logic              wb_rw_q,    wb_rw_d;
    logic              wb_lf_q,    wb_lf_d;
    logic [4:0]        wb_rd_q,    wb_rd_d;
    logic [XLEN-1:0]   wb_res_q,   wb_res_d;

    logic            mem_op;
    logic            misaligned;
    logic            stall_raw;
    logic            misal_raw;
    logic [XLEN-1:0] store_src;
    logic [XLEN-1:0] lane_wdata;
    logic [3:0]      lane_be;
    logic [XLEN-1:0] rd_shifted;
    logic [XLEN-1:0] load_fmt;

    assign mem_op    = valid_EXMEM & (store_flag_EXMEM | load_flag_EXMEM);
    // MEM/WB still holds the older instruction during the accept cycle
    assign store_src = forward_mem ? wb_res_q : rs2_data_EXMEM;

    // Alignment check on the effective address
    always_comb begin
        misaligned = 1'b0;
        case (funct3_EXMEM[1:0])
            2'b01:   misaligned = alu_result_EXMEM[0];
            2'b10:   misaligned = (alu_result_EXMEM[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    // Store data replication and byte-enable generation
    always_comb begin
        lane_wdata = store_src;
        lane_be    = 4'b1111;
        if (store_flag_EXMEM) begin
            case (funct3_EXMEM[1:0])
                2'b00: begin
                    lane_wdata = {(XLEN/8){store_src[7:0]}};
                    lane_be    = 4'b0001 << alu_result_EXMEM[1:0];
                end
                2'b01: begin
                    lane_wdata = {(XLEN/16){store_src[15:0]}};
                    lane_be    = alu_result_EXMEM[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    lane_wdata = store_src;
                    lane_be    = 4'b1111;
                end
            endcase
        end
    end

    // Load lane selection and sign/zero extension
    always_comb begin
        rd_shifted = dmem_rdata >> {req_off_q, 3'b000};
        case (req_f3_q)
            3'b000:  load_fmt = {{(XLEN-8){rd_shifted[7]}}, rd_shifted[7:0]};
            3'b100:  load_fmt = {{(XLEN-8){1'b0}}, rd_shifted[7:0]};
            3'b001:  load_fmt = {{(XLEN-16){rd_shifted[15]}}, rd_shifted[15:0]};
            3'b101:  load_fmt = {{(XLEN-16){1'b0}}, rd_shifted[15:0]};
            default: load_fmt = dmem_rdata;
        endcase
    end

    // Next-state, request capture and MEM/WB update
    always_comb begin
        state_d     = state_q;
        req_addr_d  = req_addr_q;
        req_off_d   = req_off_q;
        req_f3_d    = req_f3_q;
        req_rd_d    = req_rd_q;
        req_store_d = req_store_q;
        req_be_d    = req_be_q;
        req_wdata_d = req_wdata_q;
        wb_valid_d  = wb_valid_q;
        wb_rw_d     = wb_rw_q;
        wb_lf_d     = wb_lf_q;
        wb_rd_d     = wb_rd_q;
        wb_res_d    = wb_res_q;
        stall_raw   = 1'b0;
        misal_raw   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    wb_valid_d = 1'b0;
                    wb_rw_d    = 1'b0;
                    wb_lf_d    = 1'b0;
                    wb_rd_d    = '0;
                    wb_res_d   = '0;
                    if (misaligned) begin
                        misal_raw = 1'b1;
                    end else begin
                        stall_raw   = 1'b1;
                        req_addr_d  = {alu_result_EXMEM[ADDR_W-1:2], 2'b00};
                        req_off_d   = alu_result_EXMEM[1:0];
                        req_f3_d    = funct3_EXMEM;
                        req_rd_d    = rd_EXMEM;
                        req_store_d = store_flag_EXMEM;
                        req_be_d    = lane_be;
                        req_wdata_d = lane_wdata;
                        state_d     = REQ;
                    end
                end else begin
                    wb_valid_d = valid_EXMEM;
                    wb_rw_d    = reg_write_EXMEM;
                    wb_lf_d    = load_flag_EXMEM;
                    wb_rd_d    = rd_EXMEM;
                    wb_res_d   = alu_result_EXMEM;
                end
            end
            REQ: begin
                if (dmem_ready) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = req_rd_q;
                    if (req_store_q) begin
                        wb_rw_d  = 1'b0;
                        wb_lf_d  = 1'b0;
                        wb_res_d = '0;
                    end else begin
                        wb_rw_d  = (req_rd_q != 5'd0);
                        wb_lf_d  = 1'b1;
                        wb_res_d = load_fmt;
                    end
                end else begin
                    stall_raw = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Request and MEM/WB registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_addr_q  <= '0;
            req_off_q   <= '0;
            req_f3_q    <= '0;
            req_rd_q    <= '0;
            req_store_q <= 1'b0;
            req_be_q    <= '0;
            req_wdata_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_rw_q     <= 1'b0;
            wb_lf_q     <= 1'b0;
            wb_rd_q     <= '0;
            wb_res_q    <= '0;
        end else begin
            req_addr_q  <= req_addr_d;
            req_off_q   <= req_off_d;
            req_f3_q    <= req_f3_d;
            req_rd_q    <= req_rd_d;
            req_store_q <= req_store_d;
            req_be_q    <= req_be_d;
            req_wdata_q <= req_wdata_d;
            wb_valid_q  <= wb_valid_d;
            wb_rw_q     <= wb_rw_d;
            wb_lf_q     <= wb_lf_d;
            wb_rd_q     <= wb_rd_d;
            wb_res_q    <= wb_res_d;
        end
    end

    // Combinational outputs are forced low while reset is held
    assign stall_mem       = rst_n & stall_raw;
    assign misaligned_exc  = rst_n & misal_raw;
    assign dmem_req        = (state_q == REQ);
    assign dmem_we         = (state_q == REQ) & req_store_q;
    assign dmem_addr       = req_addr_q;
    assign dmem_be         = req_be_q;
    assign dmem_wdata      = req_wdata_q;
    assign valid_MEMWB     = wb_valid_q;
    assign reg_write_MEMWB = wb_rw_q;
    assign load_flag_MEMWB = wb_lf_q;
    assign rd_MEMWB        = wb_rd_q;
    assign result_MEMWB    = wb_res_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed-vector bench for mem_stage_lsu.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_EXMEM;
    logic [31:0] alu_result_EXMEM;
    logic [31:0] rs2_data_EXMEM;
    logic [4:0]  rd_EXMEM;
    logic [2:0]  funct3_EXMEM;
    logic        store_flag_EXMEM;
    logic        load_flag_EXMEM;
    logic        reg_write_EXMEM;
    logic        forward_mem;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        stall_mem;
    logic        misaligned_exc;
    logic        valid_MEMWB;
    logic        reg_write_MEMWB;
    logic        load_flag_MEMWB;
    logic [4:0]  rd_MEMWB;
    logic [31:0] result_MEMWB;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_stage_lsu #(.XLEN(32), .ADDR_W(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .valid_EXMEM      (valid_EXMEM),
        .alu_result_EXMEM (alu_result_EXMEM),
        .rs2_data_EXMEM   (rs2_data_EXMEM),
        .rd_EXMEM         (rd_EXMEM),
        .funct3_EXMEM     (funct3_EXMEM),
        .store_flag_EXMEM (store_flag_EXMEM),
        .load_flag_EXMEM  (load_flag_EXMEM),
        .reg_write_EXMEM  (reg_write_EXMEM),
        .forward_mem      (forward_mem),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_be          (dmem_be),
        .dmem_wdata       (dmem_wdata),
        .dmem_ready       (dmem_ready),
        .dmem_rdata       (dmem_rdata),
        .stall_mem        (stall_mem),
        .misaligned_exc   (misaligned_exc),
        .valid_MEMWB      (valid_MEMWB),
        .reg_write_MEMWB  (reg_write_MEMWB),
        .load_flag_MEMWB  (load_flag_MEMWB),
        .rd_MEMWB         (rd_MEMWB),
        .result_MEMWB     (result_MEMWB)
    );

    typedef struct {
        logic        v, ld, st, rw, fwd;
        logic [2:0]  f3;
        logic [31:0] addr, rs2, rdata;
        logic [4:0]  rd;
        int unsigned dly;
        // expectations
        logic        e_req, e_misal, e_we, e_chkw;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_v, e_rw, e_lf, e_chkd;
        logic [4:0]  e_rd;
        logic [31:0] e_res;
    } vec_t;

    localparam int NV = 18;
    vec_t vt [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t v_alu(input logic [4:0] rd, input logic [31:0] res);
        vec_t t = '{default: '0};
        t.v = 1'b1; t.rw = 1'b1; t.rd = rd; t.addr = res; t.rs2 = 32'h5A5A5A5A;
        t.e_v = 1'b1; t.e_rw = 1'b1; t.e_chkd = 1'b1; t.e_rd = rd; t.e_res = res;
        return t;
    endfunction

    function automatic vec_t v_ld(input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [4:0] rd, input logic [31:0] rdata,
                                  input int unsigned dly, input logic e_rw,
                                  input logic [31:0] res);
        vec_t t = '{default: '0};
        t.v = 1'b1; t.ld = 1'b1; t.rw = 1'b1; t.f3 = f3; t.addr = addr; t.rd = rd;
        t.rdata = rdata; t.dly = dly; t.rs2 = 32'hA5A5A5A5;
        t.e_req = 1'b1; t.e_be = 4'b1111;
        t.e_v = 1'b1; t.e_rw = e_rw; t.e_lf = 1'b1; t.e_chkd = 1'b1; t.e_rd = rd; t.e_res = res;
        return t;
    endfunction

    function automatic vec_t v_st(input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] rs2, input logic fwd,
                                  input int unsigned dly, input logic [3:0] be,
                                  input logic [31:0] wdata);
        vec_t t = '{default: '0};
        t.v = 1'b1; t.st = 1'b1; t.f3 = f3; t.addr = addr; t.rs2 = rs2; t.fwd = fwd;
        t.rd = 5'd31; t.dly = dly;
        t.e_req = 1'b1; t.e_we = 1'b1; t.e_chkw = 1'b1; t.e_be = be; t.e_wdata = wdata;
        t.e_v = 1'b1;
        return t;
    endfunction

    function automatic vec_t v_mis(input logic ld, input logic [2:0] f3, input logic [31:0] addr);
        vec_t t = '{default: '0};
        t.v = 1'b1; t.ld = ld; t.st = ~ld; t.rw = ld; t.f3 = f3; t.addr = addr; t.rd = 5'd9;
        t.e_misal = 1'b1;
        return t;
    endfunction

    task automatic drive_ex(input vec_t t);
        valid_EXMEM      = t.v;
        alu_result_EXMEM = t.addr;
        rs2_data_EXMEM   = t.rs2;
        rd_EXMEM         = t.rd;
        funct3_EXMEM     = t.f3;
        store_flag_EXMEM = t.st;
        load_flag_EXMEM  = t.ld;
        reg_write_EXMEM  = t.rw;
        forward_mem      = t.fwd;
        dmem_rdata       = t.rdata;
    endtask

    task automatic clear_ex();
        valid_EXMEM      = 1'b0;
        alu_result_EXMEM = '0;
        rd_EXMEM         = '0;
        funct3_EXMEM     = '0;
        store_flag_EXMEM = 1'b0;
        load_flag_EXMEM  = 1'b0;
        reg_write_EXMEM  = 1'b0;
        forward_mem      = 1'b0;
    endtask

    task automatic chk_wb(input vec_t t, input int idx);
        string s;
        s = $sformatf("wb[%0d]", idx);
        chk({s, ".valid"}, {31'b0, valid_MEMWB}, {31'b0, t.e_v});
        chk({s, ".reg_write"}, {31'b0, reg_write_MEMWB}, {31'b0, t.e_rw});
        chk({s, ".load_flag"}, {31'b0, load_flag_MEMWB}, {31'b0, t.e_lf});
        if (t.e_chkd) begin
            chk({s, ".rd"}, {27'b0, rd_MEMWB}, {27'b0, t.e_rd});
            chk({s, ".result"}, result_MEMWB, t.e_res);
        end
    endtask

    initial begin
        vt[0]  = v_alu(5'd1, 32'h12345678);
        vt[1]  = v_ld(3'b010, 32'h00000100, 5'd2, 32'hDEADBEEF, 1, 1'b1, 32'hDEADBEEF);
        vt[2]  = v_ld(3'b000, 32'h00000103, 5'd3, 32'h80112233, 0, 1'b1, 32'hFFFFFF80);
        vt[3]  = v_ld(3'b100, 32'h00000103, 5'd4, 32'h80112233, 0, 1'b1, 32'h00000080);
        vt[4]  = v_ld(3'b001, 32'h00000102, 5'd6, 32'h80011234, 2, 1'b1, 32'hFFFF8001);
        vt[5]  = v_ld(3'b101, 32'h00000102, 5'd7, 32'h80011234, 0, 1'b1, 32'h00008001);
        vt[6]  = v_ld(3'b000, 32'h00000101, 5'd8, 32'h11223344, 0, 1'b1, 32'h00000033);
        vt[7]  = v_ld(3'b010, 32'h00000040, 5'd5, 32'h000000AB, 0, 1'b1, 32'h000000AB);
        vt[8]  = v_st(3'b000, 32'h00000202, 32'h55555555, 1'b1, 1, 4'b0100, 32'hABABABAB);
        vt[9]  = v_mis(1'b0, 3'b001, 32'h00000301);
        vt[10] = v_st(3'b001, 32'h00000302, 32'h1234BEEF, 1'b0, 0, 4'b1100, 32'hBEEFBEEF);
        vt[11] = v_mis(1'b1, 3'b010, 32'h00000105);
        vt[12] = v_alu(5'd9, 32'h0BADF00D);
        vt[13] = v_st(3'b010, 32'h00000304, 32'hCAFEF00D, 1'b0, 3, 4'b1111, 32'hCAFEF00D);
        vt[14] = v_alu(5'd10, 32'h00000ABC);
        vt[15] = v_ld(3'b010, 32'h00000100, 5'd0, 32'h11111111, 0, 1'b0, 32'h11111111);
        vt[16] = v_st(3'b000, 32'h00000201, 32'h000000C3, 1'b0, 0, 4'b0010, 32'hC3C3C3C3);
        vt[17] = v_ld(3'b001, 32'h00000106, 5'd11, 32'h7FFF0000, 1, 1'b1, 32'h00007FFF);

        // Reset with an aligned load and dmem_ready presented: all outputs low
        rst_n = 1'b0;
        drive_ex(vt[1]);
        dmem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.dmem_req", {31'b0, dmem_req}, 32'd0);
        chk("rst.dmem_we", {31'b0, dmem_we}, 32'd0);
        chk("rst.stall_mem", {31'b0, stall_mem}, 32'd0);
        chk("rst.misaligned", {31'b0, misaligned_exc}, 32'd0);
        chk("rst.valid_MEMWB", {31'b0, valid_MEMWB}, 32'd0);
        chk("rst.reg_write", {31'b0, reg_write_MEMWB}, 32'd0);
        chk("rst.load_flag", {31'b0, load_flag_MEMWB}, 32'd0);
        chk("rst.rd", {27'b0, rd_MEMWB}, 32'd0);
        chk("rst.result", result_MEMWB, 32'd0);
        chk("rst.dmem_be", {28'b0, dmem_be}, 32'd0);
        chk("rst.dmem_addr", dmem_addr, 32'd0);
        clear_ex();
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven stream; each vector's MEM/WB result is checked while the next is presented
        for (int i = 0; i < NV; i++) begin
            drive_ex(vt[i]);
            dmem_ready = 1'b1;  // ready while idle must be ignored
            @(negedge clk);
            if (i > 0) chk_wb(vt[i-1], i - 1);
            chk($sformatf("v%0d.stall_accept", i), {31'b0, stall_mem}, {31'b0, vt[i].e_req});
            chk($sformatf("v%0d.misaligned", i), {31'b0, misaligned_exc}, {31'b0, vt[i].e_misal});
            chk($sformatf("v%0d.req_idle", i), {31'b0, dmem_req}, 32'd0);
            @(posedge clk); #1;
            if (vt[i].e_req) begin
                clear_ex();
                for (int unsigned k = 0; k <= vt[i].dly; k++) begin
                    dmem_ready = (k == vt[i].dly);
                    @(negedge clk);
                    chk($sformatf("v%0d.req%0d", i, k), {31'b0, dmem_req}, 32'd1);
                    chk($sformatf("v%0d.we", i), {31'b0, dmem_we}, {31'b0, vt[i].e_we});
                    chk($sformatf("v%0d.addr", i), dmem_addr, vt[i].addr & 32'hFFFFFFFC);
                    chk($sformatf("v%0d.be", i), {28'b0, dmem_be}, {28'b0, vt[i].e_be});
                    if (vt[i].e_chkw)
                        chk($sformatf("v%0d.wdata", i), dmem_wdata, vt[i].e_wdata);
                    chk($sformatf("v%0d.stall%0d", i, k), {31'b0, stall_mem},
                        {31'b0, (k != vt[i].dly)});
                    chk($sformatf("v%0d.wb_bubble", i), {31'b0, valid_MEMWB}, 32'd0);
                    @(posedge clk); #1;
                end
            end
        end
        clear_ex();
        dmem_ready = 1'b0;
        @(negedge clk);
        chk_wb(vt[NV-1], NV - 1);
        @(posedge clk); #1;

        // Reset asserted while a request is outstanding
        drive_ex(vt[1]);
        dmem_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rreq.dmem_req_before", {31'b0, dmem_req}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rreq.dmem_req", {31'b0, dmem_req}, 32'd0);
        chk("rreq.stall_mem", {31'b0, stall_mem}, 32'd0);
        chk("rreq.valid_MEMWB", {31'b0, valid_MEMWB}, 32'd0);
        chk("rreq.result", result_MEMWB, 32'd0);
        drive_ex(v_mis(1'b1, 3'b010, 32'h00000101));
        #1;
        chk("rreq.misaligned", {31'b0, misaligned_exc}, 32'd0);
        drive_ex(v_alu(5'd12, 32'h000055AA));
        dmem_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rrel.dmem_req", {31'b0, dmem_req}, 32'd0);
        chk("rrel.valid", {31'b0, valid_MEMWB}, 32'd1);
        chk("rrel.reg_write", {31'b0, reg_write_MEMWB}, 32'd1);
        chk("rrel.rd", {27'b0, rd_MEMWB}, 32'd12);
        chk("rrel.result", result_MEMWB, 32'h000055AA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
